// File: rtl/snake_tracker.sv
// snake_tracker: segment store, step/collision FSM and pixel query for the snake game.
// Define SNAKE_WRAP_EN to make the border wrap instead of killing the snake.
module snake_tracker #(
  parameter int COORD_W = 4,
  parameter int MAX_LEN = 16,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic               move,
  input  logic [1:0]         dir,
  input  logic               grow,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               isBorder,
  output logic               isHead,
  output logic               isBody,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   length,
  output logic               game_over,
  output logic               running
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RIGHT = 2'b11;

  localparam logic [COORD_W-1:0] GRID_MAX = '1;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] MID = ONE << (COORD_W - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [1:0]         state;
  logic [1:0]         last_dir;
  logic [LEN_W-1:0]   len_q;
  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];

  logic [1:0]         eff_dir;
  logic [COORD_W-1:0] nx, ny;
  logic [COORD_W-1:0] wx, wy;
  logic               grow_eff;
  logic               hit_border;
  logic               hit_self;
  logic               collide;

  function automatic logic on_border(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    return (a == '0) || (a == GRID_MAX) ||
           (b == '0) || (b == GRID_MAX);
  endfunction

  // A reversal would fold the head onto seg[1]; keep going instead.
  always_comb begin
    eff_dir = dir;
    if (dir == {last_dir[1], ~last_dir[0]} && len_q > LEN_ONE)
      eff_dir = last_dir;
  end

  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    unique case (eff_dir)
      UP:    ny = seg_y[0] - ONE;
      DOWN:  ny = seg_y[0] + ONE;
      LEFT:  nx = seg_x[0] - ONE;
      RIGHT: nx = seg_x[0] + ONE;
      default: ;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  always_comb begin
    wx = nx;
    wy = ny;
    if (nx == '0) wx = GRID_MAX - ONE;
    else if (nx == GRID_MAX) wx = ONE;
    if (ny == '0) wy = GRID_MAX - ONE;
    else if (ny == GRID_MAX) wy = ONE;
    hit_border = 1'b0;
  end
`else
  always_comb begin
    wx = nx;
    wy = ny;
    hit_border = on_border(nx, ny);
  end
`endif

  assign grow_eff = grow && (len_q < LEN_MAX);

  // Tail cell is free unless the snake grows this step.
  always_comb begin
    hit_self = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_q &&
          (grow_eff || LEN_W'(i) != len_q - LEN_ONE) &&
          seg_x[i] == wx && seg_y[i] == wy)
        hit_self = 1'b1;
    end
  end

  assign collide = hit_border || hit_self;

  always_comb begin
    isBody = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_q &&
          seg_x[i] == x && seg_y[i] == y)
        isBody = 1'b1;
    end
  end

  assign isHead   = (x == seg_x[0]) && (y == seg_y[0]);
  assign isBorder = on_border(x, y);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      last_dir <= RIGHT;
      len_q    <= LEN_ONE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0] <= MID;
      seg_y[0] <= MID;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (move) begin
            if (collide) begin
              state <= DEAD;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0] <= wx;
              seg_y[0] <= wy;
              last_dir <= eff_dir;
              if (grow_eff) len_q <= len_q + LEN_ONE;
            end
          end
        end
        DEAD: begin
          if (start) begin
            state    <= IDLE;
            last_dir <= RIGHT;
            len_q    <= LEN_ONE;
            for (int i = 0; i < MAX_LEN; i++) begin
              seg_x[i] <= '0;
              seg_y[i] <= '0;
            end
            seg_x[0] <= MID;
            seg_y[0] <= MID;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign length    = len_q;
  assign game_over = (state == DEAD);
  assign running   = (state == RUN);

endmodule

// File: doc/snake_tracker.md
# snake_tracker

Sequential, parametrised successor to the combinational border generator: holds the snake's segment coordinates on a square grid and advances the head one cell per move pulse. Also detects border and self collisions, grows on request, and answers a combinational pixel query (border / head / body) for the display scanner. It sits between the game-control FSM (which issues `move`, `dir`, `grow`, `start`) and the pixel/render logic.

## Interface
Parameters:
- `COORD_W`, 4: coordinate width in bits.
  - Grid is `2**COORD_W` square; `GRID_MAX = 2**COORD_W-1`.
- `MAX_LEN`, 16: maximum snake length in segments (≥2).

Ports:
- `clk` in 1: system clock.
- `nRst` in 1: reset, asynchronous, active-low.
- `start` in 1: level, sampled each cycle.
- `move` in 1: single-cycle step request.
- `dir` in 2: requested direction.
  - 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- `grow` in 1: sampled only with `move`; lengthens the snake by one.
- `x`, `y` in `COORD_W`: query coordinate.
- `isBorder` out 1: query cell lies on the border.
- `isHead` out 1: query cell is the head.
- `isBody` out 1: query cell is a non-head segment.
- `head_x`, `head_y` out `COORD_W`: current head position.
- `length` out `$clog2(MAX_LEN+1)`: current length.
- `game_over` out 1: high in DEAD.
- `running` out 1: high in RUN.

## Operation
- Storage: segment array `seg[0..MAX_LEN-1]` of (x,y); `seg[0]` is the head. Only indices `< length` are valid.
- FSM states IDLE, RUN, DEAD:
  - IDLE→RUN on `start`.
  - RUN→DEAD on a collision.
  - DEAD→IDLE on `start`, which also re-initialises the snake.
  - `start` in RUN is ignored. `move` in IDLE/DEAD is ignored.
- Init (reset or restart):
  - `length=1`, `seg[0]=(2**(COORD_W-1), 2**(COORD_W-1))`, i.e. (8,8) at default.
  - Last direction = right.
- Direction filter:
  - If `dir` is the reverse of the last applied direction and `length>1`, the last direction is used instead.
  - Otherwise `dir` is used and becomes the last direction.
- Next head = `seg[0]` + unit step in the effective direction.
- Border: `x==0 || x==GRID_MAX || y==0 || y==GRID_MAX`.
- Collision, evaluated on `move` in RUN:
  - The next head is on the border, or
  - The next head equals any valid `seg[i]`, i≥1. Exception: `seg[length-1]` is excluded when not growing, since the tail vacates.
- On collision: go to DEAD; segments, length and head are unchanged.
- On a legal move:
  - Shift `seg[i]←seg[i-1]` for all i, then `seg[0]←next head`.
  - If `grow` and `length<MAX_LEN`, `length` increments; otherwise `length` is unchanged.
  - `grow` at `MAX_LEN` is ignored (length saturates); the move still occurs.
- Query outputs are purely combinational from `x`, `y` and registered state:
  - `isHead` = (x,y)==`seg[0]`.
  - `isBody` = match on any valid i≥1.
  - `isBorder` is independent of state.
  - `isHead` and `isBody` are valid in all states, including DEAD.
- Reset: all outputs take their init values.
  - IDLE, `length=1`, `head=(8,8)`, `game_over=0`, `running=0`.
  - Query outputs reflect the init snake.

## Timing
- `move` is accepted on the rising edge where it is high in RUN.
- `head_x/head_y`, `length`, `game_over` and the query outputs reflect the move from the next cycle.
- `move` may be asserted on consecutive cycles; each high cycle is one step.
- `start` and `move` high in the same cycle while in IDLE: the transition to RUN happens and the move is ignored.
- `nRst` asserted mid-operation immediately clears to init state, regardless of clock.
- `grow` without `move` has no effect.

## Configuration
- `SNAKE_WRAP_EN` defined: the border is not fatal.
  - A next head landing on coordinate 0 wraps to `GRID_MAX-1`.
  - A next head landing on `GRID_MAX` wraps to 1.
  - Wrapping applies per axis. Self-collision is then checked on the wrapped position.
  - `isBorder` query behaviour is unchanged.
- Not defined: border entry is a collision and the FSM goes to DEAD.

## Test plan
- Reset: `nRst` low then high → IDLE, `length=1`, head (8,8). Query (8,8) gives `isHead=1`. Query (0,1) gives `isBorder=1`, `isBody=0`.
- `start`, then 3× `move` with `dir=11` → `running=1`, head (11,8), `length=1`. Query (10,8) gives `isBody=0`.
- From (11,8): `move` with `grow=1`, `dir=11` → head (12,8), `length=2`, query (11,8) gives `isBody=1`. Then `move`, `dir=10` (reverse) → head (13,8), `length` stays 2.
- Head at (14,8) heading right, `move` `dir=11`:
  - Without `SNAKE_WRAP_EN` → `game_over=1` and head stays (14,8). Further `move` has no effect. `start` returns to IDLE at (8,8).
  - With `SNAKE_WRAP_EN` → head (1,8) and `running=1`.
- Length 5, segments (8,8),(7,8),(6,8),(5,8),(4,8): moves down, left, up → the third move targets (7,8) = `seg[3]` → `game_over=1`, `length=5`.
- Tail exception: length 4, square path right, down, left, up returns to the tail cell with `grow=0` → legal, no DEAD. Repeating the same path with `grow=1` on the last move → DEAD.
